// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with carry/borrow chain, wrap pulse and a
// time-multiplexed common-anode 7-segment driver with leading-zero blanking.

// One BCD digit. Steps up or down and rolls over at the terminal value
// (9 going up, 0 going down). term tells the next digit to step with it.
module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       step,
    input  logic       up,
    output logic [3:0] q,
    output logic       term
);
    assign term = up ? (q == 4'd9) : (q == 4'd0);

    // digit register; only values 0..9 are ever loaded
    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= 4'd0;
        else if (step)
            q <= term ? (up ? 4'd0 : 4'd9) : (up ? q + 4'd1 : q - 4'd1);
    end
endmodule

module bcd_counter_display #(
    parameter int DIGITS   = 4,
    parameter int CLK_HZ   = 100000000,
    parameter int COUNT_HZ = 1,
    parameter int SCAN_HZ  = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw,
    input  logic       up,
    input  logic       clr,
    output logic [6:0] seg,
    output logic [3:0] AN,
    output logic       ovf
);
    localparam int COUNT_DIV = CLK_HZ / COUNT_HZ;
    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int CW        = $clog2(COUNT_DIV);
    localparam int SW        = $clog2(SCAN_DIV);

    logic [CW-1:0]          cnt_pre;
    logic [SW-1:0]          scan_pre;
    logic [1:0]             idx;
    logic                   tick;
    logic                   scan_tc;
    logic [DIGITS:0]        carry;
    logic [DIGITS-1:0]      term;
    logic [DIGITS-1:0][3:0] dig;
    logic [3:0][3:0]        dig4;
    logic [3:0]             cur;
    logic                   blank;
    logic [6:0]             seg_d;
    logic [3:0]             an_d;

    assign tick    = (cnt_pre == CW'(COUNT_DIV - 1));
    assign scan_tc = (scan_pre == SW'(SCAN_DIV - 1));

    // count prescaler: free-running regardless of sw, restarted by clr
    always_ff @(posedge clk) begin
        if (rst || clr || tick)
            cnt_pre <= '0;
        else
            cnt_pre <= cnt_pre + CW'(1);
    end

    // scan prescaler and digit index; clr and sw do not disturb the scan
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_pre <= '0;
            idx      <= 2'd0;
        end else if (scan_tc) begin
            scan_pre <= '0;
            idx      <= (idx == 2'(DIGITS - 1)) ? 2'd0 : idx + 2'd1;
        end else begin
            scan_pre <= scan_pre + SW'(1);
        end
    end

    // carry/borrow ripples up while lower digits sit at their terminal value
    assign carry[0] = tick & sw;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bcd_digit u_dig (
                .clk  (clk),
                .rst  (rst),
                .clr  (clr),
                .step (carry[g]),
                .up   (up),
                .q    (dig[g]),
                .term (term[g])
            );
            assign carry[g+1] = carry[g] & term[g];
        end
    endgenerate

    // wrap pulse lands on the same edge as the wrapped value
    always_ff @(posedge clk) begin
        if (rst || clr)
            ovf <= 1'b0;
        else
            ovf <= carry[DIGITS];
    end

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h7F;
        endcase
    endfunction

    // select the scanned digit; blank it if it and everything above are zero
    always_comb begin
        dig4 = '0;
        for (int i = 0; i < DIGITS; i++)
            dig4[i] = dig[i];
        cur   = dig4[idx];
        blank = 1'b0;
        if (BLANK_LZ != 0 && idx != 2'd0) begin
            blank = 1'b1;
            for (int i = 0; i < 4; i++)
                if (i >= int'(idx) && dig4[i] != 4'd0)
                    blank = 1'b0;
        end
        an_d  = 4'hF;
        seg_d = 7'h7F;
        if (!blank) begin
            an_d[idx] = 1'b0;
            seg_d     = enc(cur);
        end
    end

    // registered segment/anode drive to the pins
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 7'h7F;
            AN  <= 4'hF;
        end else begin
            seg <= seg_d;
            AN  <= an_d;
        end
    end
endmodule

// File: tb/tb_bcd_counter_display.sv
// Scoreboard bench: stimulus pushes expected seg/AN/ovf per cycle and expected
// ovf pulse cycles; a negedge monitor pops and compares.
module tb_bcd_counter_display;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sw, up, clr;
    logic [6:0] seg;
    logic [3:0] an;
    logic ovf;
    logic rst2, sw2, up2, clr2;
    logic [6:0] seg2;
    logic [3:0] an2;
    logic ovf2;

    bcd_counter_display #(.DIGITS(4), .CLK_HZ(100), .COUNT_HZ(10), .SCAN_HZ(25), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .sw(sw), .up(up), .clr(clr), .seg(seg), .AN(an), .ovf(ovf));

    bcd_counter_display #(.DIGITS(2), .CLK_HZ(100), .COUNT_HZ(10), .SCAN_HZ(25), .BLANK_LZ(0)) dut2 (
        .clk(clk), .rst(rst2), .sw(sw2), .up(up2), .clr(clr2), .seg(seg2), .AN(an2), .ovf(ovf2));

    typedef struct {
        int         cyc;
        bit         which;
        logic [6:0] seg;
        logic [3:0] an;
        logic       ovf;
        string      name;
    } exp_t;

    exp_t sq[$];
    int   oq[$];
    int   oq2[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   base = 0;
    int   base2 = 0;
    int   hk, slot;
    logic [6:0] m_seg;
    logic [3:0] m_an;
    logic       m_ovf;
    bit         hit;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ex(input bit w, input int k, input logic [6:0] s, input logic [3:0] a,
                      input logic o, input string nm);
        exp_t e;
        e.cyc = (w ? base2 : base) + k;
        e.which = w;
        e.seg = s;
        e.an = a;
        e.ovf = o;
        e.name = nm;
        sq.push_back(e);
    endtask

    // monitor: compare display outputs and ovf pulses against the scoreboard
    always @(negedge clk) begin
        for (int i = sq.size() - 1; i >= 0; i--) begin
            if (sq[i].cyc <= cyc) begin
                tests++;
                m_seg = sq[i].which ? seg2 : seg;
                m_an  = sq[i].which ? an2 : an;
                m_ovf = sq[i].which ? ovf2 : ovf;
                if (sq[i].cyc < cyc) begin
                    fails++;
                    $display("FAIL %s: check for cycle %0d not taken (now %0d)", sq[i].name, sq[i].cyc, cyc);
                end else if (m_seg !== sq[i].seg || m_an !== sq[i].an || m_ovf !== sq[i].ovf) begin
                    fails++;
                    $display("FAIL %s @%0d: got seg=%h AN=%h ovf=%b, expected seg=%h AN=%h ovf=%b",
                             sq[i].name, cyc, m_seg, m_an, m_ovf, sq[i].seg, sq[i].an, sq[i].ovf);
                end
                sq.delete(i);
            end
        end
        if (ovf === 1'b1) begin
            tests++;
            hit = 1'b0;
            for (int i = oq.size() - 1; i >= 0; i--)
                if (oq[i] == cyc) begin hit = 1'b1; oq.delete(i); end
            if (!hit) begin
                fails++;
                $display("FAIL ovf: got pulse at cycle %0d, expected none", cyc);
            end
        end
        for (int i = oq.size() - 1; i >= 0; i--)
            if (oq[i] < cyc) begin
                tests++; fails++;
                $display("FAIL ovf: got no pulse at cycle %0d, expected 1", oq[i]);
                oq.delete(i);
            end
        if (ovf2 === 1'b1) begin
            tests++;
            hit = 1'b0;
            for (int i = oq2.size() - 1; i >= 0; i--)
                if (oq2[i] == cyc) begin hit = 1'b1; oq2.delete(i); end
            if (!hit) begin
                fails++;
                $display("FAIL ovf2: got pulse at cycle %0d, expected none", cyc);
            end
        end
        for (int i = oq2.size() - 1; i >= 0; i--)
            if (oq2[i] < cyc) begin
                tests++; fails++;
                $display("FAIL ovf2: got no pulse at cycle %0d, expected 1", oq2[i]);
                oq2.delete(i);
            end
    end

    initial begin
        rst = 1; sw = 0; up = 1; clr = 0;
        rst2 = 1; sw2 = 0; up2 = 1; clr2 = 0;
        step(2);
        // count a little, then reset mid-count and mid-scan
        rst = 0; sw = 1;
        step(23);
        rst = 1; base = cyc;
        for (int i = 1; i <= 3; i++) ex(0, i, 7'h7F, 4'hF, 1'b0, "in_reset");
        step(3);

        // up count from 0000; k = edges since release
        rst = 0; base = cyc;
        ex(0, 1,   7'h40, 4'hE, 1'b0, "first_after_reset");
        ex(0, 37,  7'h7F, 4'hF, 1'b0, "lz_blank_slot1");
        ex(0, 49,  7'h19, 4'hE, 1'b0, "up_digit0_is_4");
        ex(0, 101, 7'h79, 4'hD, 1'b0, "v0010_slot1");
        ex(0, 105, 7'h7F, 4'hF, 1'b0, "v0010_slot2");
        ex(0, 109, 7'h7F, 4'hF, 1'b0, "v0010_slot3");
        ex(0, 113, 7'h40, 4'hE, 1'b0, "v0010_slot0");
        step(100); sw = 0;                  // k=100, value 0010
        step(13); clr = 1; sw = 1; up = 0;  // clear at edge 114
        step(1); clr = 0;
        oq.push_back(base + 124);
        ex(0, 124, 7'h7F, 4'hF, 1'b1, "down_wrap_ovf");
        ex(0, 125, 7'h10, 4'h7, 1'b0, "v9999_slot3");
        step(10); up = 1;                   // k=124
        ex(0, 129, 7'h10, 4'hE, 1'b0, "v9999_slot0");
        ex(0, 133, 7'h10, 4'hD, 1'b0, "v9999_slot1");
        oq.push_back(base + 134);
        ex(0, 135, 7'h7F, 4'hF, 1'b0, "up_wrap_0000_slot1");
        step(10);                           // k=134, value 0000
        ex(0, 545, 7'h79, 4'hE, 1'b0, "v0041_slot0");
        ex(0, 549, 7'h19, 4'hD, 1'b0, "v0041_slot1");
        step(425); clr = 1;                 // k=559, value 0042, prescaler 5
        step(1); clr = 0;                   // k=560
        ex(0, 561, 7'h40, 4'hE, 1'b0, "clr_mid_count");
        ex(0, 577, 7'h79, 4'hE, 1'b0, "one_after_clr");
        step(10); up = 0;                   // k=570, value 0001
        step(19); clr = 1;                  // k=589, value 0000, tick next edge
        step(1); clr = 0;                   // k=590
        ex(0, 590, 7'h7F, 4'hF, 1'b0, "clr_with_tick");
        ex(0, 593, 7'h40, 4'hE, 1'b0, "clr_with_tick_val");
        oq.push_back(base + 600);
        step(10); up = 1;                   // k=600, value 9999
        oq.push_back(base + 610);
        step(380); sw = 0;                  // k=980, value 0037

        // hold: value stays 0037 while the scan keeps rotating
        for (int j = 0; j < 125; j++) begin
            hk = 984 + 4 * j;
            slot = ((hk - 1) / 4) % 4;
            case (slot)
                0:       ex(0, hk, 7'h78, 4'hE, 1'b0, "hold_slot0");
                1:       ex(0, hk, 7'h30, 4'hD, 1'b0, "hold_slot1");
                default: ex(0, hk, 7'h7F, 4'hF, 1'b0, "hold_blank");
            endcase
        end
        step(500);

        // two-digit instance without blanking
        rst2 = 0; sw2 = 1; up2 = 0; base2 = cyc;
        ex(1, 1,  7'h40, 4'hE, 1'b0, "d2_first");
        ex(1, 5,  7'h40, 4'hD, 1'b0, "d2_no_blank");
        ex(1, 10, 7'h40, 4'hE, 1'b1, "d2_down_wrap");
        oq2.push_back(base2 + 10);
        ex(1, 13, 7'h10, 4'hD, 1'b0, "d2_99_slot1");
        ex(1, 17, 7'h10, 4'hE, 1'b0, "d2_99_slot0");
        ex(1, 20, 7'h10, 4'hE, 1'b1, "d2_up_wrap");
        oq2.push_back(base2 + 20);
        ex(1, 21, 7'h40, 4'hD, 1'b0, "d2_00_slot1");
        ex(1, 25, 7'h40, 4'hE, 1'b0, "d2_00_slot0");
        step(10); up2 = 1;
        step(20);

        step(3);
        tests++;
        if (sq.size() + oq.size() + oq2.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending checks, expected 0", sq.size() + oq.size() + oq2.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcd_counter_display.md
Name: bcd_counter_display

Overview:
- Parametrised multi-digit BCD up/down counter with a time-multiplexed common-anode 7-segment driver.
- Next generation of the single-digit 0-9 counter/divider/decoder chain.
- Adds:
  - 1..4 digits with carry/borrow
  - direction control and synchronous clear
  - wrap indication
  - leading-zero blanking
  - an integrated count-rate prescaler and scan-rate prescaler.
- Sits at board top level, driving seg/AN directly.

Parameters:
- DIGITS, 4, number of BCD digits displayed and counted (1..4).
- CLK_HZ, 100000000, input clock frequency.
- COUNT_HZ, 1, count tick rate; COUNT_DIV = CLK_HZ/COUNT_HZ, must be >= 2.
- SCAN_HZ, 1000, digit advance rate; SCAN_DIV = CLK_HZ/SCAN_HZ, must be >= 2.
- BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all digits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sw  in  1  count enable; 1 = count on each tick, 0 = hold value
- up  in  1  direction; 1 = increment, 0 = decrement; sampled on tick cycle
- clr  in  1  synchronous clear of count value and count prescaler
- seg  out  7  segment cathodes, active-low, seg[6]=g .. seg[0]=a
- AN  out  4  digit anodes, active-low, AN[0] = least significant digit
- ovf  out  1  one-cycle pulse when the count wraps

Behaviour:
- Reset values:
  - digits all 0, both prescalers 0, scan index 0
  - seg=7'h7F, AN=4'hF, ovf=0
  - All state clears on the edge where rst=1, including mid-count or mid-scan.
- Priority per edge: rst > clr > tick.
- Count prescaler:
  - Runs 0..COUNT_DIV-1 regardless of sw.
  - tick is internal and asserted in the cycle the prescaler equals COUNT_DIV-1; the prescaler then returns to 0.
  - clr forces prescaler to 0, digits to 0, ovf to 0.
  - First tick after clr release occurs exactly COUNT_DIV cycles later.
- Counting occurs on tick with sw=1; the new value is visible in the internal digit registers on the following edge.
  - Up: digit0+1; a digit at 9 becomes 0 and carries into the next digit.
  - Down: digit0-1; a digit at 0 becomes 9 and borrows from the next digit.
  - Up wrap: all digits 9 -> all 0, ovf=1 for exactly that one cycle, coincident with the new value.
  - Down wrap: all digits 0 -> all 9, ovf=1 likewise.
  - sw=0: value held, ovf=0; prescaler keeps running.
- Digit values are always in 0..9; no illegal BCD reachable.
- Scan:
  - A scan prescaler counts 0..SCAN_DIV-1.
  - On terminal count, scan index advances idx -> idx+1, with DIGITS-1 -> 0.
  - Independent of sw/clr.
- Output registers:
  - seg/AN are recomputed every cycle from the current idx and digit registers; latency 1 cycle.
  - AN: bit idx = 0, all others 1; AN bits >= DIGITS always 1.
  - Blanking (BLANK_LZ=1): digit i > 0 is blanked when digits i..DIGITS-1 are all 0. Blanked means AN all 1 and seg=7'h7F for that slot. Digit 0 is never blanked.
- Encoding (gfedcba, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
- First cycle after reset release: AN=4'hE, seg=7'h40.

Test Plan (CLK_HZ=100, COUNT_HZ=10 -> COUNT_DIV=10, SCAN_HZ=25 -> SCAN_DIV=4, DIGITS=4, BLANK_LZ=1 unless stated):
- Reset: rst=1 for 3 cycles mid-count -> during reset AN=F, seg=7F, ovf=0. One cycle after release -> AN=E, seg=40.
- Up count: sw=1, up=1 for 100 cycles -> value 0010.
  - Scan slot 0: AN=E, seg=40.
  - Scan slot 1: AN=D, seg=79.
  - Slots 2/3: AN=F, seg=7F.
  - ovf never high.
- Down wrap: from 0000, sw=1, up=0, first tick -> value 9999, ovf high exactly 1 cycle; every slot lit with seg=10.
  - Then set up=1; next tick -> 0000 with one ovf pulse.
- Clear mid-count: at value 0042 with prescaler=5, pulse clr for 1 cycle.
  - Next cycle value 0000.
  - Next increment to 0001 exactly 10 cycles after clr deasserts.
  - clr asserted together with tick -> value 0000, no ovf.
- Hold: sw=0 for 500 cycles at 0037 -> value stays 0037, scan keeps cycling AN=E,D,(blank),(blank) every 4 cycles, ovf=0.
- DIGITS=2, BLANK_LZ=0 instance: up from 99 -> 00 with ovf pulse.
  - AN[3:2] always 1.
  - Both digits shown with seg=40 (no blanking).
